wb_queue: RTL and testbench

Writeback queue between the pipeline's result producers (MEM/WB stage, multi-cycle units) and the register file write port. Accepts register writes through a valid/ready handshake, buffers up to DEPTH of them in order, and drains one per cycle into the register file when granted. Provides two combinational forwarding lookups so the decode stage can see values that are queued but not yet written to the register file.

---
 rtl/wb_queue.sv | 115 +++++++++++
 tb/tb_wb_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue: buffers register writes in order, drains one per
// granted cycle into the register file, and forwards queued values.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain_en,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] lk_addr1,
  input  logic [AW-1:0] lk_addr2,
  output logic          lk_hit1,
  output logic          lk_hit2,
  output logic [DW-1:0] lk_data1,
  output logic [DW-1:0] lk_data2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;

  logic is_empty;
  logic is_full;
  logic push;
  logic store;
  logic pop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  assign empty    = rst || is_empty;
  assign full     = !rst && is_full;
  assign count    = rst ? '0 : count_q;
  assign in_ready = !rst && !is_full;

  assign push  = in_valid && in_ready;
  // r0 writes complete the handshake but are dropped
  assign store = push && (in_addr != '0);
  assign pop   = drain_en && !empty;

  assign rf_we = pop;
  assign rf_wa = empty ? '0 : addr_q[head];
  assign rf_wd = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (store)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      unique case ({store, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [AW-1:0] lk_addr [2];
  logic          lk_hit  [2];
  logic [DW-1:0] lk_data [2];

  assign lk_addr[0] = lk_addr1;
  assign lk_addr[1] = lk_addr2;
  assign lk_hit1    = lk_hit[0];
  assign lk_hit2    = lk_hit[1];
  assign lk_data1   = lk_data[0];
  assign lk_data2   = lk_data[1];

  // Scan oldest to youngest so the last match wins
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      lk_hit[p]  = 1'b0;
      lk_data[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if (!rst && (CW'(k) < count_q) &&
            (lk_addr[p] != '0) &&
            (addr_q[idx] == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue.
// Inputs change #1 after a rising edge; outputs checked before the next.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  lk_addr1;
  logic [4:0]  lk_addr2;
  logic        lk_hit1;
  logic        lk_hit2;
  logic [31:0] lk_data1;
  logic [31:0] lk_data2;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .drain_en(drain_en),
    .rf_we(rf_we),
    .rf_wa(rf_wa),
    .rf_wd(rf_wd),
    .lk_addr1(lk_addr1),
    .lk_addr2(lk_addr2),
    .lk_hit1(lk_hit1),
    .lk_hit2(lk_hit2),
    .lk_data1(lk_data1),
    .lk_data2(lk_data2),
    .count(count),
    .empty(empty),
    .full(full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [4:0] a, logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    drain_en = 1'b0;
    lk_addr1 = 5'd3;
    lk_addr2 = '0;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_hit", 32'(lk_hit1), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // single write
    drain_en = 1'b1;
    push(5'd3, 32'h1111_0003);
    #1;
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_wa", 32'(rf_wa), 32'd3);
    chk("t1_wd", rf_wd, 32'h1111_0003);
    chk("t1_hit", 32'(lk_hit1), 32'd1);
    chk("t1_data", lk_data1, 32'h1111_0003);
    tick();
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_we_off", 32'(rf_we), 32'd0);
    chk("t1_hit_off", 32'(lk_hit1), 32'd0);

    // fill and stall
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++)
      push(5'(i), 32'hA0 + 32'(i));
    in_valid = 1'b1;
    in_addr  = 5'd5;
    in_data  = 32'hA5;
    #1;
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t2_count_hold", 32'(count), 32'd4);
    drain_en = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_we", 32'(rf_we), 32'd1);
      chk("t2_wa", 32'(rf_wa), 32'(i));
      chk("t2_wd", rf_wd, 32'hA0 + 32'(i));
      tick();
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_we_off", 32'(rf_we), 32'd0);

    // youngest-wins forwarding
    drain_en = 1'b0;
    push(5'd5, 32'h10);
    push(5'd6, 32'h20);
    push(5'd5, 32'h30);
    lk_addr1 = 5'd5;
    lk_addr2 = 5'd6;
    #1;
    chk("t3_hit1", 32'(lk_hit1), 32'd1);
    chk("t3_data1", lk_data1, 32'h30);
    chk("t3_hit2", 32'(lk_hit2), 32'd1);
    chk("t3_data2", lk_data2, 32'h20);
    lk_addr1 = 5'd7;
    #1;
    chk("t3_miss_hit", 32'(lk_hit1), 32'd0);
    chk("t3_miss_data", lk_data1, 32'd0);
    drain_en = 1'b1;
    #1;
    chk("t3_wa0", 32'(rf_wa), 32'd5);
    chk("t3_wd0", rf_wd, 32'h10);
    tick();
    chk("t3_wa1", 32'(rf_wa), 32'd6);
    chk("t3_wd1", rf_wd, 32'h20);
    tick();
    chk("t3_wa2", 32'(rf_wa), 32'd5);
    chk("t3_wd2", rf_wd, 32'h30);
    tick();
    chk("t3_empty", 32'(empty), 32'd1);

    // r0 discard
    drain_en = 1'b0;
    push(5'd0, 32'hDEAD);
    chk("t4_r0_count", 32'(count), 32'd0);
    push(5'd2, 32'hBEEF);
    lk_addr1 = 5'd0;
    #1;
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_hit0", 32'(lk_hit1), 32'd0);
    drain_en = 1'b1;
    #1;
    chk("t4_wa", 32'(rf_wa), 32'd2);
    chk("t4_wd", rf_wd, 32'hBEEF);
    tick();
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_we_off", 32'(rf_we), 32'd0);

    // simultaneous push/pop across pointer wrap
    drain_en = 1'b0;
    push(5'd1, 32'h100);
    push(5'd2, 32'h101);
    drain_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1;
      in_addr  = 5'(j + 3);
      in_data  = 32'h102 + 32'(j);
      #1;
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_we", 32'(rf_we), 32'd1);
      chk("t5_wd", rf_wd, 32'h100 + 32'(j));
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("t5_tail0", rf_wd, 32'h10A);
    tick();
    chk("t5_tail1", rf_wd, 32'h10B);
    tick();
    chk("t5_empty", 32'(empty), 32'd1);

    // mid-operation reset
    drain_en = 1'b0;
    push(5'd7, 32'h70);
    push(5'd8, 32'h80);
    push(5'd9, 32'h90);
    chk("t6_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    tick();
    rst = 1'b0;
    drain_en = 1'b1;
    #1;
    chk("t6_we", 32'(rf_we), 32'd0);
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t6_we_later", 32'(rf_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
